// File: rtl/game_pkg.sv
// Shared types and constants for the 2048 game engine: direction/state encodings,
// LFSR parameters and the power-on board pattern.
package game_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MERGE,
        S_SPAWN,
        S_CHECK,
        S_END
    } state_t;

    localparam int unsigned         LFSR_W      = 16;
    localparam logic [LFSR_W-1:0]   LFSR_MASK   = 16'hB400;
    localparam int unsigned         MAX_BOARD_W = 4096;

    // Cell (0,0) and cell (n-1,n-1) hold exponent 1; callers keep the low n*n*tw bits.
    function automatic logic [MAX_BOARD_W-1:0] reset_board(input int unsigned n, input int unsigned tw);
        logic [MAX_BOARD_W-1:0] b;
        b = '0;
        b[0] = 1'b1;
        b[(n*n-1)*tw] = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational 2048 line move: input ordered wall-first, compacts toward the wall,
// merges equal pairs once (wall side first) and reports score gained and change.
module line_merge #(
    parameter int unsigned N       = 4,
    parameter int unsigned TW      = 4,
    parameter int unsigned SCORE_W = 20
) (
    input  logic [N*TW-1:0]    line_in,
    output logic [N*TW-1:0]    line_out,
    output logic [SCORE_W-1:0] delta,
    output logic               changed
);

    localparam logic [TW-1:0] SAT = '1;

    // One spare zero entry so the pair lookahead never leaves the array.
    logic [TW-1:0] comp [N+1];

    always_comb begin
        int unsigned        k;
        logic               skip;
        logic               carry;
        logic [TW-1:0]      a;
        logic [TW-1:0]      b;
        logic [SCORE_W-1:0] acc;
        logic [SCORE_W-1:0] inc;

        for (int unsigned i = 0; i <= N; i++) comp[i] = '0;
        k = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (line_in[i*TW +: TW] != '0) begin
                comp[k] = line_in[i*TW +: TW];
                k = k + 1;
            end
        end

        line_out = '0;
        acc      = '0;
        skip     = 1'b0;
        carry    = 1'b0;
        inc      = '0;
        k        = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else begin
                a = comp[i];
                b = comp[i+1];
                if (a != '0 && a == b && a != SAT) begin
                    line_out[k*TW +: TW] = a + TW'(1);
                    skip = 1'b1;
                    if (int'(a) + 1 >= int'(SCORE_W)) begin
                        acc = '1;
                    end else begin
                        inc = '0;
                        inc[int'(a) + 1] = 1'b1;
                        {carry, acc} = {1'b0, acc} + {1'b0, inc};
                        if (carry) acc = '1;
                    end
                end else begin
                    line_out[k*TW +: TW] = a;
                end
                k = k + 1;
            end
        end

        delta   = acc;
        changed = (line_out != line_in);
    end

endmodule

// File: rtl/game_engine.sv
// NxN 2048 engine: board/score/move state, one line merged per cycle through a shared
// datapath, LFSR-driven tile spawn, and win/loss detection.
module game_engine
    import game_pkg::*;
#(
    parameter int unsigned       N       = 4,
    parameter int unsigned       TW      = 4,
    parameter int unsigned       WIN_EXP = 11,
    parameter int unsigned       SCORE_W = 20,
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart,
    input  logic                 load,
    input  logic [N*N*TW-1:0]    load_board,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd_dir,
    output logic                 cmd_ready,
    output logic [N*N*TW-1:0]    board,
    output logic [SCORE_W-1:0]   score,
    output logic [15:0]          moves,
    output logic                 won,
    output logic                 lost
);

    localparam int unsigned BW    = N*N*TW;
    localparam int unsigned CELLS = N*N;
    localparam int unsigned IW    = $clog2(N);
    localparam logic [MAX_BOARD_W-1:0] RESET_FULL  = reset_board(N, TW);
    localparam logic [BW-1:0]          RESET_BOARD = RESET_FULL[BW-1:0];

    state_t              state;
    dir_t                dir;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       work;
    logic [SCORE_W-1:0]  work_score;
    logic                changed;
    logic [LFSR_W-1:0]   lfsr;

    logic [N*TW-1:0]     line_in;
    logic [N*TW-1:0]     lm_out;
    logic [SCORE_W-1:0]  lm_delta;
    logic                lm_changed;
    logic [SCORE_W:0]    score_sum;
    logic [SCORE_W-1:0]  merged_score;
    logic [BW-1:0]       spawn_board;
    logic [TW-1:0]       spawn_val;
    logic [LFSR_W-1:0]   lfsr_next;
    logic                win_now;
    logic                lost_now;

    function automatic logic [TW-1:0] cell_of(input logic [BW-1:0] b, input int unsigned k);
        return b[k*TW +: TW];
    endfunction

    // Element i of a line counts from the wall the tiles slide toward.
    function automatic int unsigned cell_pos(input dir_t d, input int unsigned line, input int unsigned i);
        case (d)
            DIR_UP:   return i*N + line;
            DIR_DOWN: return (N-1-i)*N + line;
            DIR_LEFT: return line*N + i;
            default:  return line*N + (N-1-i);
        endcase
    endfunction

    assign cmd_ready = (state == S_IDLE);

    always_comb begin
        line_in = '0;
        for (int unsigned i = 0; i < N; i++)
            line_in[i*TW +: TW] = cell_of(work, cell_pos(dir, int'(idx), i));
    end

    line_merge #(.N(N), .TW(TW), .SCORE_W(SCORE_W)) u_merge (
        .line_in  (line_in),
        .line_out (lm_out),
        .delta    (lm_delta),
        .changed  (lm_changed)
    );

    assign score_sum    = {1'b0, work_score} + {1'b0, lm_delta};
    assign merged_score = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign lfsr_next    = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
    assign spawn_val    = (lfsr[15:12] == 4'd0) ? TW'(2) : TW'(1);

    always_comb begin
        int unsigned empties;
        int unsigned pick;
        int unsigned seen;
        empties = 0;
        for (int unsigned k = 0; k < CELLS; k++)
            if (cell_of(work, k) == '0) empties = empties + 1;
        pick = (empties == 0) ? 0 : int'(lfsr) % empties;
        spawn_board = work;
        seen = 0;
        for (int unsigned k = 0; k < CELLS; k++) begin
            if (cell_of(work, k) == '0) begin
                if (seen == pick) spawn_board[k*TW +: TW] = spawn_val;
                seen = seen + 1;
            end
        end
    end

    always_comb begin
        logic has_empty;
        logic has_pair;
        win_now   = 1'b0;
        has_empty = 1'b0;
        has_pair  = 1'b0;
        for (int unsigned k = 0; k < CELLS; k++) begin
            if (cell_of(board, k) == TW'(WIN_EXP)) win_now = 1'b1;
            if (cell_of(board, k) == '0) has_empty = 1'b1;
        end
        for (int unsigned r = 0; r < N; r++)
            for (int unsigned c = 0; c + 1 < N; c++)
                if (cell_of(board, r*N + c) == cell_of(board, r*N + c + 1)) has_pair = 1'b1;
        for (int unsigned r = 0; r + 1 < N; r++)
            for (int unsigned c = 0; c < N; c++)
                if (cell_of(board, r*N + c) == cell_of(board, (r+1)*N + c)) has_pair = 1'b1;
        lost_now = !has_empty && !has_pair;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            dir        <= DIR_UP;
            idx        <= '0;
            work       <= '0;
            work_score <= '0;
            changed    <= 1'b0;
            lfsr       <= SEED;
            board      <= RESET_BOARD;
            score      <= '0;
            moves      <= '0;
            won        <= 1'b0;
            lost       <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            if (restart) begin
                state <= S_IDLE;
                lfsr  <= SEED;
                board <= RESET_BOARD;
                score <= '0;
                moves <= '0;
                won   <= 1'b0;
                lost  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_END: begin
                        if (load) begin
                            board <= load_board;
                            won   <= 1'b0;
                            lost  <= 1'b0;
                            state <= S_CHECK;
                        end else if (state == S_IDLE && cmd_valid) begin
                            dir        <= dir_t'(cmd_dir);
                            work       <= board;
                            work_score <= score;
                            changed    <= 1'b0;
                            idx        <= '0;
                            state      <= S_MERGE;
                        end
                    end
                    S_MERGE: begin
                        for (int unsigned i = 0; i < N; i++)
                            work[cell_pos(dir, int'(idx), i)*TW +: TW] <= lm_out[i*TW +: TW];
                        work_score <= merged_score;
                        changed    <= changed | lm_changed;
                        if (idx == IW'(N-1))
                            state <= (changed | lm_changed) ? S_SPAWN : S_CHECK;
                        else
                            idx <= idx + IW'(1);
                    end
                    S_SPAWN: begin
                        board <= spawn_board;
                        score <= work_score;
                        moves <= moves + 16'd1;
                        state <= S_CHECK;
                    end
                    S_CHECK: begin
                        won   <= won | win_now;
                        lost  <= lost | lost_now;
                        state <= (win_now || lost_now) ? S_END : S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_engine.sv
// Scoreboard bench for game_engine (N=4, TW=4): stimulus queues expected results,
// a monitor pops and compares on each completion event (ready rise, won/lost rise, rst).
module tb_game_engine;

    localparam int unsigned BW = 64;
    localparam int unsigned SW = 20;

    localparam logic [BW-1:0] ALL   = '1;
    localparam logic [BW-1:0] RB    = 64'h1000_0000_0000_0001;
    localparam logic [BW-1:0] ROW4  = 64'h0000_0000_0000_1111;
    localparam logic [BW-1:0] ROW22 = 64'h0000_0000_0000_0022;
    localparam logic [BW-1:0] COL0  = 64'h0004_0003_0002_0001;
    localparam logic [BW-1:0] ROWAA = 64'h0000_0000_0000_00AA;
    localparam logic [BW-1:0] WINB  = 64'h0000_0000_0000_000B;
    localparam logic [BW-1:0] CHK   = 64'h1212_2121_1212_2121;
    localparam logic [BW-1:0] SAT   = 64'h1212_2121_1212_21FF;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            restart = 1'b0;
    logic            load = 1'b0;
    logic [BW-1:0]   load_board = '0;
    logic            cmd_valid = 1'b0;
    logic [1:0]      cmd_dir = 2'b00;
    logic            cmd_ready;
    logic [BW-1:0]   board;
    logic [SW-1:0]   score;
    logic [15:0]     moves;
    logic            won;
    logic            lost;

    game_engine #(.N(4), .TW(4), .WIN_EXP(11), .SCORE_W(20), .SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .load       (load),
        .load_board (load_board),
        .cmd_valid  (cmd_valid),
        .cmd_dir    (cmd_dir),
        .cmd_ready  (cmd_ready),
        .board      (board),
        .score      (score),
        .moves      (moves),
        .won        (won),
        .lost       (lost)
    );

    always #5 clk = ~clk;

    // ready_low: >0 expected low-cycle count, 0 means cmd_ready must be high now, -1 skip.
    typedef struct {
        string          name;
        logic [BW-1:0]  brd;
        logic [BW-1:0]  mask;
        bit             spawn;
        logic [SW-1:0]  sc;
        logic [15:0]    mv;
        bit             w;
        bit             l;
        int             ready_low;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string what, input string nm, input logic [BW-1:0] act, input logic [BW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s: got %h, required %h", nm, what, act, req);
        end
    endtask

    task automatic expect_ev(input string nm, input logic [BW-1:0] b, input logic [BW-1:0] m,
                             input bit sp, input int sc, input int mv, input bit w, input bit l, input int rl);
        exp_t e;
        e.name = nm; e.brd = b; e.mask = m; e.spawn = sp;
        e.sc = SW'(sc); e.mv = 16'(mv); e.w = w; e.l = l; e.ready_low = rl;
        sbq.push_back(e);
    endtask

    task automatic compare_pop(input int seen_low);
        exp_t          e;
        int            nz;
        bit            bad;
        logic [BW-1:0] tmp;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got output event at %0t, required none queued", $time);
            return;
        end
        e = sbq.pop_front();
        chk("board", e.name, board & e.mask, e.brd & e.mask);
        chk("score", e.name, 64'(score), 64'(e.sc));
        chk("moves", e.name, 64'(moves), 64'(e.mv));
        chk("won",   e.name, 64'(won),   64'(e.w));
        chk("lost",  e.name, 64'(lost),  64'(e.l));
        if (e.spawn) begin
            nz = 0;
            bad = 1'b0;
            for (int k = 0; k < 16; k++) begin
                tmp = board >> (k*4);
                if (!e.mask[k*4] && tmp[3:0] != 4'd0) begin
                    nz++;
                    if (tmp[3:0] > 4'd2) bad = 1'b1;
                end
            end
            chk("spawn_tiles", e.name, 64'(nz + (bad ? 100 : 0)), 64'd1);
        end
        if (e.ready_low == 0)
            chk("cmd_ready", e.name, 64'(cmd_ready), 64'd1);
        else if (e.ready_low > 0)
            chk("ready_low_cycles", e.name, 64'(seen_low), 64'(e.ready_low));
    endtask

    initial begin : monitor
        logic prev_ready = 1'b1;
        logic prev_won = 1'b0;
        logic prev_lost = 1'b0;
        logic prev_rst = 1'b0;
        int   low_cnt = 0;
        bit   trig;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                if (!prev_rst) begin
                    #1;
                    compare_pop(-1);
                end
                prev_rst   = 1'b1;
                low_cnt    = 0;
                prev_ready = cmd_ready;
                prev_won   = won;
                prev_lost  = lost;
            end else begin
                prev_rst = 1'b0;
                trig = (cmd_ready && !prev_ready) || (won && !prev_won) || (lost && !prev_lost);
                if (trig) compare_pop(low_cnt);
                low_cnt    = cmd_ready ? 0 : low_cnt + 1;
                prev_ready = cmd_ready;
                prev_won   = won;
                prev_lost  = lost;
            end
        end
    end

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic do_load(input logic [BW-1:0] b);
        @(posedge clk); #1;
        load_board = b;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic do_move(input logic [1:0] d);
        @(posedge clk); #1;
        cmd_dir = d;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_restart();
        @(posedge clk); #1;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish by %0t, required finish", $time);
        $fatal(1);
    end

    initial begin : stimulus
        exp_t e;
        #1;
        expect_ev("reset", RB, ALL, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        settle();

        // Four equal tiles merge into two pairs, +4 each.
        expect_ev("load_row4", ROW4, ALL, 0, 0, 0, 0, 0, 1);
        do_load(ROW4); settle();
        expect_ev("left_row4", ROW22, 64'hFF, 1, 8, 1, 0, 0, 6);
        do_move(2'b10); settle();

        // Already-packed distinct column: nothing moves.
        expect_ev("load_col0", COL0, ALL, 0, 8, 1, 0, 0, 1);
        do_load(COL0); settle();
        expect_ev("up_nochange", COL0, ALL, 0, 8, 1, 0, 0, 5);
        do_move(2'b00); settle();

        // 10+10 -> 11 wins and parks the engine in END.
        expect_ev("load_aa", ROWAA, ALL, 0, 8, 1, 0, 0, 1);
        do_load(ROWAA); settle();
        expect_ev("left_win", WINB, 64'hF, 1, 2056, 2, 1, 0, -1);
        do_move(2'b10); settle();
        @(posedge clk); #1;
        cmd_dir = 2'b01;
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 cmd_valid = 1'b0;
        settle();
        expect_ev("reload_win", WINB, ALL, 0, 2056, 2, 1, 0, -1);
        do_load(WINB); settle();
        expect_ev("restart_end", RB, ALL, 0, 0, 0, 0, 0, -1);
        do_restart(); settle();

        // Full checkerboard has no move; saturated 15s never merge.
        expect_ev("load_lost", CHK, ALL, 0, 0, 0, 0, 1, -1);
        do_load(CHK); settle();
        expect_ev("load_sat", SAT, ALL, 0, 0, 0, 0, 0, -1);
        do_load(SAT); settle();
        expect_ev("left_sat", SAT, ALL, 0, 0, 0, 0, 0, 5);
        do_move(2'b10); settle();

        // restart in the second MERGE cycle abandons the move.
        expect_ev("load_row4b", ROW4, ALL, 0, 0, 0, 0, 0, 1);
        do_load(ROW4); settle();
        expect_ev("restart_merge", RB, ALL, 0, 0, 0, 0, 0, 2);
        do_move(2'b10);
        @(posedge clk); #1;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        settle();

        // Build non-reset state, then hit rst during SPAWN.
        expect_ev("load_row4c", ROW4, ALL, 0, 0, 0, 0, 0, 1);
        do_load(ROW4); settle();
        expect_ev("left_row4c", ROW22, 64'hFF, 1, 8, 1, 0, 0, 6);
        do_move(2'b10); settle();
        expect_ev("load_22", ROW22, ALL, 0, 8, 1, 0, 0, 1);
        do_load(ROW22); settle();
        expect_ev("rst_spawn", RB, ALL, 0, 0, 0, 0, 0, 0);
        do_move(2'b10);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        settle();

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            failures++;
            $display("FAIL %s.event: got no output event, required one", e.name);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
